// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : VGA mode constant sets, control-bundle type and total helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    typedef struct packed {
        int h_visible;
        int h_front;
        int h_sync;
        int h_back;
        int v_visible;
        int v_front;
        int v_sync;
        int v_back;
        bit hs_pol;
        bit vs_pol;
        int clk_div;
    } vga_mode_t;

    // Sync levels are carried already polarity-encoded.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } vga_ctrl_t;

    function automatic int vga_total(input int visible, input int front,
                                     input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    localparam vga_mode_t MODE_640x480_60 = '{
        h_visible: 640, h_front: 16, h_sync: 96,  h_back: 48,
        v_visible: 480, v_front: 10, v_sync: 2,   v_back: 33,
        hs_pol: 1'b0, vs_pol: 1'b0, clk_div: 2
    };

    localparam vga_mode_t MODE_800x600_72 = '{
        h_visible: 800, h_front: 56, h_sync: 120, h_back: 64,
        v_visible: 600, v_front: 37, v_sync: 6,   v_back: 23,
        hs_pol: 1'b1, vs_pol: 1'b1, clk_div: 1
    };

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : vga_delay_line
// Description : 3-bit shift register with clock-enable and reset-load value;
//               wire-through when DEPTH is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_delay_line #(
    parameter int DEPTH = 0
) (
    input  logic       clk_50,
    input  logic       rst,
    input  logic       ce,
    input  logic [2:0] rst_val,
    input  logic [2:0] din,
    output logic [2:0] dout
);

    if (DEPTH == 0) begin : g_pass
        logic w_unused;
        assign w_unused = ^{clk_50, rst, ce, rst_val};
        assign dout     = din;
    end else begin : g_shift
        logic [2:0] r_stage [DEPTH];

        always_ff @(posedge clk_50) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_stage[i] <= rst_val;
                end
            end else if (ce) begin
                r_stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign dout = r_stage[DEPTH-1];
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator on a single clock
//               with pixel clock-enable, line/frame strobes and sync/DE delay.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = MODE_640x480_60.h_visible,
    parameter int H_FRONT   = MODE_640x480_60.h_front,
    parameter int H_SYNC    = MODE_640x480_60.h_sync,
    parameter int H_BACK    = MODE_640x480_60.h_back,
    parameter int V_VISIBLE = MODE_640x480_60.v_visible,
    parameter int V_FRONT   = MODE_640x480_60.v_front,
    parameter int V_SYNC    = MODE_640x480_60.v_sync,
    parameter int V_BACK    = MODE_640x480_60.v_back,
    parameter bit HS_POL    = MODE_640x480_60.hs_pol,
    parameter bit VS_POL    = MODE_640x480_60.vs_pol,
    parameter int CLK_DIV   = MODE_640x480_60.clk_div,
    parameter int DELAY     = 0,
    parameter int CW        = 11
) (
    input  logic          clk_50,
    input  logic          rst,
    output logic          pix_ce,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          de,
    output logic          line_start,
    output logic          frame_start
);

    localparam int c_h_total = vga_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int c_v_total = vga_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [CW-1:0] c_h_last     = CW'(c_h_total - 1);
    localparam logic [CW-1:0] c_v_last     = CW'(c_v_total - 1);
    localparam logic [CW-1:0] c_h_vis      = CW'(H_VISIBLE);
    localparam logic [CW-1:0] c_v_vis      = CW'(V_VISIBLE);
    localparam logic [CW-1:0] c_hs_start   = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] c_hs_end     = CW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] c_vs_start   = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] c_vs_end     = CW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [3:0]    c_div_last   = 4'(CLK_DIV - 1);
    localparam vga_ctrl_t     c_ctrl_idle  = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0};

    if ((2**CW) < c_h_total || (2**CW) < c_v_total) begin : g_chk_cw
        $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end
    if (DELAY < 0 || DELAY > 7) begin : g_chk_delay
        $error("vga_timing_gen: DELAY must be 0..7");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_chk_div
        $error("vga_timing_gen: CLK_DIV must be 1..16");
    end
    if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_chk_porch
        $error("vga_timing_gen: porch and sync widths must be at least 1");
    end

    logic [3:0]    r_div;
    logic [3:0]    w_div_next;
    logic          r_pix_ce;
    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          r_line_start;
    logic          r_frame_start;
    vga_ctrl_t     w_ctrl;
    vga_ctrl_t     r_ctrl;
    vga_ctrl_t     w_ctrl_out;

    // pix_ce is registered from the next divider value so it is high
    // exactly while the divider holds CLK_DIV-1.
    always_comb begin
        w_div_next = (r_div == c_div_last) ? 4'd0 : r_div + 4'd1;
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_div    <= 4'd0;
            r_pix_ce <= 1'b0;
        end else begin
            r_div    <= w_div_next;
            r_pix_ce <= (w_div_next == c_div_last);
        end
    end

    assign w_h_wrap = (r_h == c_h_last);
    assign w_v_wrap = (r_v == c_v_last);

    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_pix_ce) begin
            if (w_h_wrap) begin
                r_h <= '0;
                r_v <= w_v_wrap ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    always_comb begin
        w_ctrl    = c_ctrl_idle;
        w_ctrl.de = (r_h < c_h_vis) && (r_v < c_v_vis);
        if (r_h >= c_hs_start && r_h < c_hs_end) begin
            w_ctrl.hs = HS_POL;
        end
        if (r_v >= c_vs_start && r_v < c_vs_end) begin
            w_ctrl.vs = VS_POL;
        end
    end

    // Strobes last one clk_50 cycle: any non-wrap edge clears them.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_ctrl        <= c_ctrl_idle;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= r_pix_ce && w_h_wrap;
            r_frame_start <= r_pix_ce && w_h_wrap && w_v_wrap;
            if (r_pix_ce) begin
                r_ctrl <= w_ctrl;
            end
        end
    end

    vga_delay_line #(
        .DEPTH (DELAY)
    ) u_delay (
        .clk_50  (clk_50),
        .rst     (rst),
        .ce      (r_pix_ce),
        .rst_val (c_ctrl_idle),
        .din     (r_ctrl),
        .dout    (w_ctrl_out)
    );

    assign pix_ce      = r_pix_ce;
    assign pixel_x     = r_h;
    assign pixel_y     = r_v;
    assign vga_hs      = w_ctrl_out.hs;
    assign vga_vs      = w_ctrl_out.vs;
    assign de          = w_ctrl_out.de;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed self-checking bench for vga_timing_gen (default mode,
//               DELAY=3, 800x600 mode and a small fast-frame configuration).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk_50 = 1'b0;
    logic rst    = 1'b1;
    always #5 clk_50 = ~clk_50;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rel_cyc = 0;
    int fs_cnt = 0;
    int first_fs_cyc = -1;

    always @(posedge clk_50) cyc <= cyc + 1;

    // default mode, DELAY=0
    logic d_pce, d_hs, d_vs, d_de, d_ls, d_fs;
    logic [10:0] d_x, d_y;
    // default mode, DELAY=3
    logic t_pce, t_hs, t_vs, t_de, t_ls, t_fs;
    logic [10:0] t_x, t_y;
    // 800x600@72
    logic e_pce, e_hs, e_vs, e_de, e_ls, e_fs;
    logic [10:0] e_x, e_y;
    // small mode: H 8/2/3/3 (16), V 6/1/2/1 (10), CLK_DIV 3, DELAY 2
    logic s_pce, s_hs, s_vs, s_de, s_ls, s_fs;
    logic [4:0] s_x, s_y;

    vga_timing_gen #(.DELAY(0)) u_def (
        .clk_50(clk_50), .rst(rst), .pix_ce(d_pce), .pixel_x(d_x), .pixel_y(d_y),
        .vga_hs(d_hs), .vga_vs(d_vs), .de(d_de), .line_start(d_ls), .frame_start(d_fs));

    vga_timing_gen #(.DELAY(3)) u_d3 (
        .clk_50(clk_50), .rst(rst), .pix_ce(t_pce), .pixel_x(t_x), .pixel_y(t_y),
        .vga_hs(t_hs), .vga_vs(t_vs), .de(t_de), .line_start(t_ls), .frame_start(t_fs));

    vga_timing_gen #(
        .H_VISIBLE(800), .H_FRONT(56), .H_SYNC(120), .H_BACK(64),
        .V_VISIBLE(600), .V_FRONT(37), .V_SYNC(6), .V_BACK(23),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .DELAY(0), .CW(11)
    ) u_800 (
        .clk_50(clk_50), .rst(rst), .pix_ce(e_pce), .pixel_x(e_x), .pixel_y(e_y),
        .vga_hs(e_hs), .vga_vs(e_vs), .de(e_de), .line_start(e_ls), .frame_start(e_fs));

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .CLK_DIV(3), .DELAY(2), .CW(5)
    ) u_sm (
        .clk_50(clk_50), .rst(rst), .pix_ce(s_pce), .pixel_x(s_x), .pixel_y(s_y),
        .vga_hs(s_hs), .vga_vs(s_vs), .de(s_de), .line_start(s_ls), .frame_start(s_fs));

    // Records the first small-mode frame_start after the initial reset release.
    always @(posedge clk_50) begin
        #1;
        if (s_fs) begin
            if (fs_cnt == 0) first_fs_cyc = cyc;
            fs_cnt = fs_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick();
        total += 12;
        if (d_pce !== 1'b0) begin bad++; $display("FAIL rst_pce got=%b want=0", d_pce); end
        if (d_x !== 11'd0) begin bad++; $display("FAIL rst_x got=%0d want=0", d_x); end
        if (d_y !== 11'd0) begin bad++; $display("FAIL rst_y got=%0d want=0", d_y); end
        if (d_hs !== 1'b1) begin bad++; $display("FAIL rst_hs got=%b want=1", d_hs); end
        if (d_vs !== 1'b1) begin bad++; $display("FAIL rst_vs got=%b want=1", d_vs); end
        if (d_de !== 1'b0) begin bad++; $display("FAIL rst_de got=%b want=0", d_de); end
        if (d_ls !== 1'b0) begin bad++; $display("FAIL rst_ls got=%b want=0", d_ls); end
        if (d_fs !== 1'b0) begin bad++; $display("FAIL rst_fs got=%b want=0", d_fs); end
        if (t_hs !== 1'b1 || t_de !== 1'b0) begin bad++; $display("FAIL rst_d3 got hs=%b de=%b want hs=1 de=0", t_hs, t_de); end
        if (e_hs !== 1'b0 || e_vs !== 1'b0) begin bad++; $display("FAIL rst_800_sync got hs=%b vs=%b want 0 0", e_hs, e_vs); end
        if (e_pce !== 1'b0) begin bad++; $display("FAIL rst_800_pce got=%b want=0", e_pce); end
        if (s_vs !== 1'b0 || s_hs !== 1'b1) begin bad++; $display("FAIL rst_sm_sync got hs=%b vs=%b want 1 0", s_hs, s_vs); end
        rst = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic test_pix_ce();
        int exp_dpce [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        int exp_dx   [8] = '{0, 1, 1, 2, 2, 3, 3, 4};
        int exp_dde  [8] = '{0, 1, 1, 1, 1, 1, 1, 1};
        int exp_tde  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        int exp_spce [8] = '{0, 1, 0, 0, 1, 0, 0, 1};
        for (int k = 0; k < 8; k++) begin
            tick();
            total += 6;
            if (d_pce !== 1'(exp_dpce[k])) begin bad++; $display("FAIL pce_def[%0d] got=%b want=%0d", k, d_pce, exp_dpce[k]); end
            if (d_x !== 11'(exp_dx[k])) begin bad++; $display("FAIL x_def[%0d] got=%0d want=%0d", k, d_x, exp_dx[k]); end
            if (d_de !== 1'(exp_dde[k])) begin bad++; $display("FAIL de_rise[%0d] got=%b want=%0d", k, d_de, exp_dde[k]); end
            if (t_de !== 1'(exp_tde[k])) begin bad++; $display("FAIL de_d3[%0d] got=%b want=%0d", k, t_de, exp_tde[k]); end
            if (s_pce !== 1'(exp_spce[k])) begin bad++; $display("FAIL pce_sm[%0d] got=%b want=%0d", k, s_pce, exp_spce[k]); end
            if (e_pce !== 1'b1 || e_x !== 11'(k)) begin bad++; $display("FAIL ce800[%0d] got pce=%b x=%0d want 1 %0d", k, e_pce, e_x, k); end
        end
    endtask

    task automatic test_hsync_delay();
        int fall_d = -1, rise_d = -1, fall_t = -1, rise_t = -1;
        int def_d = -1, def_t = -1, fall_px = -1, fall_ppce = -1, fall_nx = -1, xdiff = 0;
        logic p_hs_d = d_hs, p_hs_t = t_hs, p_de_d = d_de, p_de_t = t_de, p_pce = d_pce;
        logic [10:0] p_x = d_x;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (p_hs_d && !d_hs && fall_d < 0) begin
                fall_d = cyc; fall_px = int'(p_x); fall_ppce = int'(p_pce); fall_nx = int'(d_x);
            end
            if (!p_hs_d && d_hs && fall_d >= 0 && rise_d < 0) rise_d = cyc;
            if (p_hs_t && !t_hs && fall_t < 0) fall_t = cyc;
            if (!p_hs_t && t_hs && fall_t >= 0 && rise_t < 0) rise_t = cyc;
            if (p_de_d && !d_de && def_d < 0) def_d = cyc;
            if (p_de_t && !t_de && def_t < 0) def_t = cyc;
            if (t_x !== d_x || t_y !== d_y) xdiff++;
            p_hs_d = d_hs; p_hs_t = t_hs; p_de_d = d_de; p_de_t = t_de; p_pce = d_pce; p_x = d_x;
        end
        total += 7;
        if (rise_d - fall_d != 192 || fall_d < 0) begin bad++; $display("FAIL hs_low_width got=%0d want=192", rise_d - fall_d); end
        if (fall_px != 656 || fall_ppce != 1) begin bad++; $display("FAIL hs_fall_edge got x=%0d pce=%0d want x=656 pce=1", fall_px, fall_ppce); end
        if (fall_nx != 657) begin bad++; $display("FAIL hs_fall_x got=%0d want=657", fall_nx); end
        if (fall_t - fall_d != 6 || fall_t < 0) begin bad++; $display("FAIL hs_fall_shift got=%0d want=6", fall_t - fall_d); end
        if (rise_t - rise_d != 6 || rise_t < 0) begin bad++; $display("FAIL hs_rise_shift got=%0d want=6", rise_t - rise_d); end
        if (def_t - def_d != 6 || def_t < 0) begin bad++; $display("FAIL de_fall_shift got=%0d want=6", def_t - def_d); end
        if (xdiff != 0) begin bad++; $display("FAIL coord_d3 got mismatches=%0d want=0", xdiff); end
    endtask

    task automatic test_line_period();
        int ls1 = -1, ls2 = -1, wide = 0, xbad = 0;
        logic p_ls = d_ls;
        for (int i = 0; i < 4000 && ls2 < 0; i++) begin
            tick();
            if (p_ls && d_ls) wide++;
            if (d_ls) begin
                if (d_x !== 11'd0 || d_fs !== 1'b0) xbad++;
                if (ls1 < 0) ls1 = cyc; else ls2 = cyc;
            end
            p_ls = d_ls;
        end
        tick();
        if (d_ls) wide++;
        total += 3;
        if (ls2 - ls1 != 1600 || ls1 < 0) begin bad++; $display("FAIL line_period got=%0d want=1600", ls2 - ls1); end
        if (wide != 0) begin bad++; $display("FAIL ls_width got_wide=%0d want=0", wide); end
        if (xbad != 0) begin bad++; $display("FAIL ls_at_x0 got=%0d want=0", xbad); end
    endtask

    task automatic test_800();
        int ls1 = -1, ls2 = -1, rise = -1, fall = -1, rise_x = -1, ce_low = 0;
        logic p_hs = e_hs;
        for (int i = 0; i < 2500; i++) begin
            tick();
            if (!e_pce) ce_low++;
            if (e_ls) begin
                if (ls1 < 0) ls1 = cyc; else if (ls2 < 0) ls2 = cyc;
            end
            if (!p_hs && e_hs && rise < 0) begin rise = cyc; rise_x = int'(e_x); end
            if (p_hs && !e_hs && rise >= 0 && fall < 0) fall = cyc;
            p_hs = e_hs;
        end
        total += 4;
        if (ce_low != 0) begin bad++; $display("FAIL ce800_const got_low=%0d want=0", ce_low); end
        if (ls2 - ls1 != 1040 || ls1 < 0) begin bad++; $display("FAIL line800 got=%0d want=1040", ls2 - ls1); end
        if (fall - rise != 120 || rise < 0) begin bad++; $display("FAIL hs800_width got=%0d want=120", fall - rise); end
        if (rise_x != 857) begin bad++; $display("FAIL hs800_rise_x got=%0d want=857", rise_x); end
    endtask

    task automatic test_small_frame();
        int fs1 = -1, fs2 = -1, de_cnt = 0, vs_hi = 0, ls_cnt = 0, fs_bad = 0;
        for (int i = 0; i < 1200 && fs2 < 0; i++) begin
            tick();
            if (s_fs) begin
                if (!s_ls || s_x !== 5'd0 || s_y !== 5'd0) fs_bad++;
                if (fs1 < 0) fs1 = cyc; else fs2 = cyc;
            end
            if (fs1 >= 0 && fs2 < 0) begin
                if (s_pce && s_de) de_cnt++;
                if (s_vs) vs_hi++;
                if (s_ls) ls_cnt++;
            end
        end
        total += 6;
        if (fs2 - fs1 != 480 || fs1 < 0) begin bad++; $display("FAIL frame_period got=%0d want=480", fs2 - fs1); end
        if (de_cnt != 48) begin bad++; $display("FAIL de_count got=%0d want=48", de_cnt); end
        if (vs_hi != 96) begin bad++; $display("FAIL vs_width got=%0d want=96", vs_hi); end
        if (ls_cnt != 10) begin bad++; $display("FAIL lines_per_frame got=%0d want=10", ls_cnt); end
        if (fs_bad != 0) begin bad++; $display("FAIL fs_with_ls got=%0d want=0", fs_bad); end
        if (first_fs_cyc - rel_cyc != 480) begin bad++; $display("FAIL first_frame got=%0d want=480", first_fs_cyc - rel_cyc); end
    endtask

    task automatic test_mid_reset();
        bit found = 1'b0;
        int fs_at = -1;
        int rel;
        for (int i = 0; i < 600 && !found; i++) begin
            tick();
            if (s_x == 5'd5 && s_y == 5'd3) found = 1'b1;
        end
        total += 1;
        if (!found) begin bad++; $display("FAIL mid_reset_reach got=timeout want=x5y3"); end
        rst = 1'b1;
        tick();
        total += 6;
        if (s_x !== 5'd0 || s_y !== 5'd0) begin bad++; $display("FAIL mrst_xy got=%0d,%0d want=0,0", s_x, s_y); end
        if (s_de !== 1'b0) begin bad++; $display("FAIL mrst_de got=%b want=0", s_de); end
        if (s_hs !== 1'b1 || s_vs !== 1'b0) begin bad++; $display("FAIL mrst_sync got hs=%b vs=%b want 1 0", s_hs, s_vs); end
        if (s_ls !== 1'b0 || s_fs !== 1'b0) begin bad++; $display("FAIL mrst_strobe got ls=%b fs=%b want 0 0", s_ls, s_fs); end
        if (s_pce !== 1'b0) begin bad++; $display("FAIL mrst_pce got=%b want=0", s_pce); end
        if (d_x !== 11'd0 || d_hs !== 1'b1 || d_de !== 1'b0) begin bad++; $display("FAIL mrst_def got x=%0d hs=%b de=%b want 0 1 0", d_x, d_hs, d_de); end
        rst = 1'b0;
        rel = cyc;
        for (int i = 0; i < 1000 && fs_at < 0; i++) begin
            tick();
            if (s_fs) fs_at = cyc;
        end
        total += 1;
        if (fs_at - rel != 480 || fs_at < 0) begin bad++; $display("FAIL mrst_frame got=%0d want=480", fs_at - rel); end
    endtask

    initial begin
        test_reset();
        test_pix_ce();
        test_hsync_delay();
        test_line_period();
        test_800();
        test_small_frame();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator that replaces the fixed 640x480, divide-by-two sync generator. It runs entirely on `clk_50` and uses a pixel clock-enable in place of a derived clock. Porches, sync widths and sync polarities are set by parameters. It also provides line/frame strobes for the VDP renderer and a programmable sync/DE delay line that matches renderer pipeline latency. It sits between the system clock and the VGA DAC/pins, and drives the VDP's fetch coordinates.

## Interface
- `H_VISIBLE`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixel ticks.
- `H_SYNC`, 96: horizontal sync width, in pixel ticks.
- `H_BACK`, 48: horizontal back porch, in pixel ticks.
- `V_VISIBLE`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `HS_POL`, 0: active level of `vga_hs` (0 = active-low).
- `VS_POL`, 0: active level of `vga_vs`.
- `CLK_DIV`, 2: `clk_50` cycles per pixel tick, range 1..16.
- `DELAY`, 0: extra pixel ticks of delay on `vga_hs`/`vga_vs`/`de`, range 0..7.
- `CW`, 11: coordinate counter width.
- `clk_50` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `pix_ce` out 1: pixel tick enable; one `clk_50` cycle in every `CLK_DIV`.
- `pixel_x` out CW: horizontal counter h, range 0..H_TOTAL-1.
- `pixel_y` out CW: vertical counter v, range 0..V_TOTAL-1.
- `vga_hs` out 1: horizontal sync, delayed.
- `vga_vs` out 1: vertical sync, delayed.
- `de` out 1: display enable, delayed.
- `line_start` out 1: one-cycle strobe, high in the cycle `pixel_x` first reads 0.
- `frame_start` out 1: one-cycle strobe, high in the cycle `pixel_x` and `pixel_y` first both read 0.

## Operation
- Totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL is defined likewise.
- Scan order is visible, then front porch, then sync, then back porch. Coordinate 0 is the first visible pixel.
- Divider:
  - The divider counts 0..CLK_DIV-1.
  - `pix_ce` is registered and is high in the cycle the divider equals CLK_DIV-1.
  - With CLK_DIV=1, `pix_ce` is high in every cycle after reset is released.
- Counter advance: on a clock edge where `pix_ce` is high, h increments. When h == H_TOTAL-1, h wraps to 0 and v increments. When v == V_TOTAL-1 at the same edge, v also wraps to 0.
- Region decode:
  - Visible: h<H_VISIBLE and v<V_VISIBLE.
  - HS active: H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC.
  - VS active uses the vertical equivalent.
- Output registers:
  - On each `pix_ce` edge, the decode of the pre-increment h and v is registered.
  - That value then passes through a DELAY-stage shift register, which also advances only on `pix_ce`.
  - Sync outputs drive their active level when active and the inverse otherwise.
- Strobes:
  - `line_start` is registered, and is set on the `pix_ce` edge where h == H_TOTAL-1.
  - `frame_start` is set on that same edge when v == V_TOTAL-1 as well.
  - Both are cleared on the following edge.
- Reset:
  - Reset values: h=0, v=0, divider=0, `pix_ce`=0, `line_start`=0, `frame_start`=0, `de`=0, `vga_hs`=~HS_POL, `vga_vs`=~VS_POL.
  - Every delay stage is loaded with inactive values.
  - A reset asserted mid-frame takes effect on the next edge with these same values.
  - No strobe is issued for the frame entered from reset. The first `frame_start` follows a full V_TOTAL*H_TOTAL pixel ticks.
- Elaboration checks (`$error`):
  - 2^CW must be greater than or equal to both H_TOTAL and V_TOTAL.
  - DELAY must be at most 7.
  - CLK_DIV must be in 1..16.
  - Every porch and sync parameter must be at least 1.

## Timing
- Pixel tick period is CLK_DIV cycles. Line period is H_TOTAL*CLK_DIV cycles. Frame period is H_TOTAL*V_TOTAL*CLK_DIV cycles.
- Latency from coordinate to sync/DE is DELAY+1 pixel ticks:
  - `de` for coordinate (x,y) is valid while `pixel_x` reads x+1+DELAY.
  - `pixel_x` is undelayed, so the renderer fetches ahead.
- Strobes:
  - Strobes are exactly one `clk_50` cycle wide regardless of CLK_DIV.
  - `frame_start` always coincides with a `line_start`.
- Polarity: sync outputs never glitch. They change only in the cycle after a `pix_ce` edge.

## Structure
- Package `vga_timing_pkg` holds the mode constants as localparam sets:
  - MODE_640x480_60: the defaults above, with CLK_DIV=2.
  - MODE_800x600_72: 800/56/120/64, 600/37/6/23, positive syncs, CLK_DIV=1.
  - A function computing the totals.
- Sub-module `vga_delay_line`: a parametrised-depth, 3-bit-wide shift register with clock-enable and reset-load value. It passes straight through when depth is 0.

## Test plan
- Defaults, reset released at t0: consecutive `frame_start` pulses are exactly 840000 cycles apart, and `line_start` pulses are 1600 cycles apart.
- Defaults: `vga_hs` is low for exactly 192 cycles per line, and goes low in the cycle after the `pix_ce` edge where `pixel_x` was 656. `vga_vs` is low for 2 lines (3200 cycles).
- Defaults: the count of `pix_ce` cycles with `de`=1 per frame is 307200. `de` rises in the cycle after the `pix_ce` edge that registers (0,0).
- MODE_800x600_72: `pix_ce` is constantly 1, the line period is 1040 cycles, `vga_hs` is high for 120 cycles, and the frame period is 692640 cycles.
- DELAY=3 compared with DELAY=0 on identical stimulus: `vga_hs`, `vga_vs` and `de` edges are shifted by exactly 6 cycles, and `pixel_x` is unchanged.
- Reset pulsed at `pixel_x`=300, `pixel_y`=100: the next cycle shows counters 0, `de`=0, syncs inactive and no strobes. The next `frame_start` comes 840000 cycles after reset release.
